// File: rtl/led_fade_pwm_if.sv
// Pattern handshake between the pattern generator (master) and the LED fade stage (slave).
// The pattern is offered on pat_valid/pat_data and is taken on a clock edge where pat_ready is high.
interface led_fade_pwm_if #(
    parameter int CHANNELS = 8
);
    logic                pat_valid;
    logic [CHANNELS-1:0] pat_data;
    logic                pat_ready;

    modport master (output pat_valid, output pat_data, input  pat_ready);
    modport slave  (input  pat_valid, input  pat_data, output pat_ready);
endinterface

// File: rtl/led_fade_pwm.sv
// LED fade stage: each LED ramps linearly toward full-on or off for its pattern bit,
// and is driven by a free-running PWM compare with a registered output.
module led_fade_pwm #(
    parameter int CHANNELS  = 8,
    parameter int PWM_BITS  = 8,
    parameter int STEP_DIV  = 16,
    parameter bit ACTIVE_HI = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    led_fade_pwm_if.slave       pat,
    output logic                busy,
    output logic [CHANNELS-1:0] leds
);

    localparam int              PS_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

    typedef enum logic {S_IDLE, S_FADING} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_init;
    logic [CHANNELS-1:0] r_target;
    logic [PWM_BITS-1:0] r_level [CHANNELS];
    logic [PWM_BITS-1:0] w_level_step [CHANNELS];
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PS_W-1:0]     r_prescaler;
    logic [CHANNELS-1:0] r_leds;
    logic [CHANNELS-1:0] w_on;
    logic                w_accept;
    logic                w_tick;
    logic                w_new_at_goal;
    logic                w_step_done;
    logic                w_ready;

    assign w_accept = pat.pat_valid & w_ready;
    assign w_tick   = (r_state == S_FADING) && (r_prescaler == PS_LAST);

    // Goals are only ever 0 or MAX, so "below goal" reduces to "target set and not yet MAX".
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_level_step  = r_level;
        w_new_at_goal = 1'b1;
        w_step_done   = 1'b1;
        w_on          = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_target[i]) begin
                if (r_level[i] != LVL_MAX) w_level_step[i] = r_level[i] + 1'b1;
            end else begin
                if (r_level[i] != '0) w_level_step[i] = r_level[i] - 1'b1;
            end
            if (w_level_step[i] != (r_target[i] ? LVL_MAX : '0)) w_step_done = 1'b0;
            if (r_level[i] != (pat.pat_data[i] ? LVL_MAX : '0)) w_new_at_goal = 1'b0;
            w_on[i] = (r_level[i] == LVL_MAX) || (r_level[i] > r_pwm_cnt);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: state elements use non-blocking assignments so every register samples pre-edge values.
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && !w_new_at_goal) w_state_next = S_FADING;
            S_FADING: if (w_tick && w_step_done)      w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready = (r_state == S_IDLE) && r_init;
        busy    = (r_state == S_FADING);
    end

    assign pat.pat_ready = w_ready;
    assign leds          = r_leds;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_init      <= 1'b0;
            r_target    <= '0;
            r_pwm_cnt   <= '0;
            r_prescaler <= '0;
            r_leds      <= ACTIVE_HI ? '0 : '1;
            // NOTE: the level array is a handful of flops, not a RAM, so it is cleared by reset like any other state.
            for (int i = 0; i < CHANNELS; i++) r_level[i] <= '0;
        end else begin
            r_init    <= 1'b1;
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_leds    <= w_on ^ {CHANNELS{~ACTIVE_HI}};
            if (w_accept) begin
                r_target    <= pat.pat_data;
                r_prescaler <= '0;
            end else if (r_state == S_FADING) begin
                r_prescaler <= w_tick ? '0 : r_prescaler + 1'b1;
            end else begin
                r_prescaler <= '0;
            end
            if (w_tick) r_level <= w_level_step;
        end
    end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm: a time-based fade model checks leds/busy/pat_ready every cycle,
// with directed scenarios, a slow-stepping instance for duty measurement, and random patterns.
module tb_led_fade_pwm;

    localparam int CH      = 8;
    localparam int PB      = 4;
    localparam int SD      = 2;
    localparam int MAXL    = 15;
    localparam int SD_SLOW = 128;

    logic          clk    = 1'b0;
    logic          resetn = 1'b1;
    logic          busy;
    logic          busy_slow;
    logic [CH-1:0] leds;
    logic [CH-1:0] leds_slow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    led_fade_pwm_if #(.CHANNELS(CH)) pat_if ();
    led_fade_pwm_if #(.CHANNELS(CH)) slow_if ();

    led_fade_pwm #(.CHANNELS(CH), .PWM_BITS(PB), .STEP_DIV(SD), .ACTIVE_HI(1'b1)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .pat    (pat_if),
        .busy   (busy),
        .leds   (leds)
    );

    led_fade_pwm #(.CHANNELS(CH), .PWM_BITS(PB), .STEP_DIV(SD_SLOW), .ACTIVE_HI(1'b1)) u_slow (
        .clk    (clk),
        .resetn (resetn),
        .pat    (slow_if),
        .busy   (busy_slow),
        .leds   (leds_slow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: after an accept, each LED moves one level per SD cycles from where it started
    // toward its goal, so its level is a closed-form function of cycles since the accept.
    int            m_start [CH];
    int            m_goal  [CH];
    int            m_t;
    int            m_dist;
    int            m_pwm;
    bit            m_fading;
    bit            m_rdy;
    logic [CH-1:0] m_leds;

    function automatic int m_level(input int i);
        int d;
        int s;
        d = m_goal[i] - m_start[i];
        s = m_t / SD;
        if (d >= 0) return m_start[i] + ((d < s) ? d : s);
        return m_start[i] - ((-d < s) ? -d : s);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < CH; i++) begin
            m_start[i] = 0;
            m_goal[i]  = 0;
        end
        m_t      = 0;
        m_dist   = 0;
        m_pwm    = 0;
        m_fading = 1'b0;
        m_rdy    = 1'b0;
        m_leds   = '0;
    endtask

    task automatic m_step();
        int            cur [CH];
        logic [CH-1:0] on;
        bit            acc;
        for (int i = 0; i < CH; i++) begin
            cur[i] = m_level(i);
            on[i]  = (cur[i] == MAXL) || (cur[i] > m_pwm);
        end
        acc    = pat_if.pat_valid && m_rdy && !m_fading;
        m_leds = on;
        m_pwm  = (m_pwm + 1) % (MAXL + 1);
        if (m_fading) begin
            m_t++;
            if (m_t >= SD * m_dist) m_fading = 1'b0;
        end else if (acc) begin
            m_t    = 0;
            m_dist = 0;
            for (int i = 0; i < CH; i++) begin
                int d;
                m_start[i] = cur[i];
                m_goal[i]  = pat_if.pat_data[i] ? MAXL : 0;
                d = (m_goal[i] > cur[i]) ? m_goal[i] - cur[i] : cur[i] - m_goal[i];
                if (d > m_dist) m_dist = d;
            end
            m_fading = (m_dist != 0);
        end
        m_rdy = 1'b1;
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) m_clear();
            else         m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("leds", leds, m_leds);
            check("busy", busy, m_fading);
            check("pat_ready", pat_if.pat_ready, m_rdy && !m_fading);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    // Offer a pattern and hold it until taken; returns the cycles spent waiting for pat_ready.
    task automatic send(input logic [CH-1:0] d, output int waited);
        pat_if.pat_valid = 1'b1;
        pat_if.pat_data  = d;
        waited = 0;
        while (!pat_if.pat_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        check("send_ready", pat_if.pat_ready, 1'b1);
        @(posedge clk); #1;
        pat_if.pat_valid = 1'b0;
        pat_if.pat_data  = CH'($urandom);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic count_slow_on(output int ones);
        ones = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            if (leds_slow[0]) ones++;
            check("slow_other_leds", leds_slow[7:1], 7'h00);
        end
    endtask

    initial begin
        int w;
        int n;
        int ones;
        pat_if.pat_valid  = 1'b0;
        pat_if.pat_data   = '0;
        slow_if.pat_valid = 1'b0;
        slow_if.pat_data  = '0;

        // Reset and release
        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_leds", leds, 8'h00);
        check("rst_ready", pat_if.pat_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        resetn = 1'b1;
        check("ready_before_edge", pat_if.pat_ready, 1'b0);
        @(posedge clk); #1;
        check("ready_after_edge", pat_if.pat_ready, 1'b1);
        repeat (20) begin
            @(posedge clk); #1;
            check("idle_leds", leds, 8'h00);
        end

        // PWM duty on the slow instance: level 0 then level 5
        slow_if.pat_valid = 1'b1;
        slow_if.pat_data  = 8'h01;
        check("slow_ready", slow_if.pat_ready, 1'b1);
        @(posedge clk); #1;
        slow_if.pat_valid = 1'b0;
        check("slow_busy", busy_slow, 1'b1);
        repeat (2) @(posedge clk);
        count_slow_on(ones);
        check("duty_level0", ones, 0);
        repeat (5 * SD_SLOW - 18 + 40) @(posedge clk);
        count_slow_on(ones);
        check("duty_level5", ones, 5);

        // Fade up from 0 to MAX on LED 0
        send(8'h01, w);
        check("fade_busy", busy, 1'b1);
        wait_idle(n);
        check("fade_up_cycles", n, 30);
        @(posedge clk); #1;
        repeat (16) begin
            @(posedge clk); #1;
            check("full_on", leds, 8'h01);
        end

        // Same pattern again is a no-op
        send(8'h01, w);
        check("noop_wait", w, 0);
        check("noop_busy", busy, 1'b0);
        check("noop_ready", pat_if.pat_ready, 1'b1);

        // Backpressure: 8'h80 held during a fade is taken on the first edge after it ends
        send(8'h03, w);
        pat_if.pat_valid = 1'b1;
        pat_if.pat_data  = 8'h80;
        check("bp_ready_low", pat_if.pat_ready, 1'b0);
        send(8'h80, w);
        check("bp_wait", w, 30);
        check("bp_busy", busy, 1'b1);
        wait_idle(n);
        check("bp_fade_cycles", n, 30);
        repeat (3) @(posedge clk);
        #1;
        check("bp_final", leds, 8'h80);

        // Reset mid-fade at level 7
        send(8'h01, w);
        repeat (14) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("midrst_leds", leds, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", pat_if.pat_ready, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        send(8'h01, w);
        wait_idle(n);
        check("refade_cycles", n, 30);

        // Random patterns, gaps and occasional resets
        for (int r = 0; r < 40; r++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            if ($urandom_range(0, 9) == 0) begin
                resetn = 1'b0;
                @(posedge clk); #1;
                resetn = 1'b1;
                @(posedge clk); #1;
            end
            send(CH'($urandom), w);
        end
        wait_idle(n);
        repeat (20) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
